// File: rtl/router_pkg.sv
// Shared types and constants for the router input channel.
package router_pkg;

  localparam int unsigned DEFAULT_DATA_W = 64;

  // Virtual channel indices, selected by cycle polarity
  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  typedef logic [DEFAULT_DATA_W-1:0] flit_t;

endpackage

// File: rtl/router_vc_fifo.sv
// Single virtual-channel FIFO: DEPTH entries, combinational head/full/empty.
module router_vc_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [DATA_W-1:0]              push_data,
  output logic [DATA_W-1:0]              head_c,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full_c,
  output logic                           empty_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Pointer advance with wrap at DEPTH (also correct for DEPTH == 1)
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Status and qualified handshakes
  always_comb begin
    full_c  = (count == CNT_W'(DEPTH));
    empty_c = (count == '0);
    push_ok = push && !full_c;
    pop_ok  = pop && !empty_c;
    head_c  = mem[rd_ptr];
  end

  // Pointer and occupancy state
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/router_input_channel.sv
// Router input port with two polarity-alternating virtual channels.
// Optional simulation checks: define ROUTER_INPUT_CHANNEL_ASSERT_EN.
module router_input_channel #(
  parameter int unsigned DATA_W = router_pkg::DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              send,
  input  logic              blocked,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic [DATA_W-1:0] data_out
);

  import router_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              push_even, push_odd;
  logic              pop_even,  pop_odd;
  logic [DATA_W-1:0] head_even, head_odd;
  logic [CNT_W-1:0]  cnt_even,  cnt_odd;
  logic              full_even, full_odd;
  logic              empty_even, empty_odd;

  router_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_vc_even (
    .clk(clk), .reset(reset), .push(push_even), .pop(pop_even),
    .push_data(data_in), .head_c(head_even), .count(cnt_even),
    .full_c(full_even), .empty_c(empty_even)
  );

  router_vc_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_vc_odd (
    .clk(clk), .reset(reset), .push(push_odd), .pop(pop_odd),
    .push_data(data_in), .head_c(head_odd), .count(cnt_odd),
    .full_c(full_odd), .empty_c(empty_odd)
  );

  // Link writes VC[polarity], switch reads VC[~polarity]
  always_comb begin
    push_even = 1'b0;
    push_odd  = 1'b0;
    pop_even  = 1'b0;
    pop_odd   = 1'b0;
    ready     = 1'b0;
    data_out  = '0;
    if (polarity == VC_EVEN) begin
      ready     = reset && !full_even;
      push_even = send && ready;
      pop_odd   = reset && !blocked && !empty_odd;
      if (reset && (cnt_odd != '0)) data_out = head_odd;
    end else begin
      ready     = reset && !full_odd;
      push_odd  = send && ready;
      pop_even  = reset && !blocked && !empty_even;
      if (reset && (cnt_even != '0)) data_out = head_even;
    end
  end

`ifdef ROUTER_INPUT_CHANNEL_ASSERT_EN
  // Simulation-only protocol and occupancy checks
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      if ($isunknown({polarity, send, blocked}))
        $error("router_input_channel: X on polarity/send/blocked");
      else if (send && !ready)
        $error("router_input_channel: flit dropped, data_in=%h", data_in);
      if ((cnt_even > CNT_W'(DEPTH)) || (cnt_odd > CNT_W'(DEPTH)))
        $fatal(1, "router_input_channel: VC count overflow");
      if ((pop_even && cnt_even == '0) || (pop_odd && cnt_odd == '0))
        $fatal(1, "router_input_channel: VC count underflow");
    end
  end
`else
`endif

endmodule

// File: tb/tb_router_input_channel.sv
// Scoreboard bench for router_input_channel with a queue-based VC model.
module tb_router_input_channel;

  import router_pkg::*;

  localparam int unsigned DW  = 64;
  localparam int unsigned DEP = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          polarity = 1'b0;
  logic          send = 1'b0;
  logic          blocked = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          ready;
  logic [DW-1:0] data_out;

  router_input_channel #(.DATA_W(DW), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .polarity(polarity), .send(send),
    .blocked(blocked), .data_in(data_in), .ready(ready), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic          rdy;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t    exp_q[$];
  flit_t   vc0[$];
  flit_t   vc1[$];
  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;

  // Apply one cycle of stimulus, record expected outputs, advance the model
  task automatic drive(input logic r, input logic p, input logic s,
                       input logic b, input logic [DW-1:0] d);
    exp_t e;
    int   wsz, rsz;
    flit_t rhead;
    @(negedge clk);
    reset = r; polarity = p; send = s; blocked = b; data_in = d;
    wsz   = p ? vc1.size() : vc0.size();
    rsz   = p ? vc0.size() : vc1.size();
    rhead = '0;
    if (rsz > 0) rhead = p ? vc0[0] : vc1[0];
    e.cyc = cyc;
    e.rdy = r && (wsz < DEP);
    e.dat = (r && rsz > 0) ? rhead : '0;
    exp_q.push_back(e);
    cyc++;
    if (!r) begin
      vc0.delete();
      vc1.delete();
    end else begin
      if (s && e.rdy) begin
        if (p) vc1.push_back(d); else vc0.push_back(d);
      end
      if (!b && rsz > 0) begin
        if (p) void'(vc0.pop_front()); else void'(vc1.pop_front());
      end
    end
  endtask

  // Monitor: compare DUT outputs against queued expectations mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (ready !== e.rdy) begin
          failures++;
          $display("FAIL ready cyc=%0d got=%b exp=%b", e.cyc, ready, e.rdy);
        end
        checks++;
        if (data_out !== e.dat) begin
          failures++;
          $display("FAIL data_out cyc=%0d got=%h exp=%h", e.cyc, data_out, e.dat);
        end
      end
    end
  end

  initial begin
    logic p;
    // Reset held two cycles, then released
    drive(0, 0, 1, 0, 64'hDEAD);
    drive(0, 1, 1, 0, 64'hBEEF);
    drive(1, 1, 0, 0, '0);
    // Single flit: write VC0, read next cycle, VC1 empty afterwards
    drive(1, 0, 1, 0, 64'hFA50);
    drive(1, 1, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    // Back-to-back with polarity toggling
    drive(1, 1, 1, 0, 64'hFA50);
    drive(1, 0, 1, 0, 64'h6840);
    drive(1, 1, 1, 0, 64'hFFFF);
    drive(1, 0, 1, 0, 64'hC7D4);
    drive(1, 1, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    // Blocked head holds
    drive(1, 1, 1, 0, 64'h12345678);
    drive(1, 0, 0, 1, '0);
    drive(1, 1, 0, 1, '0);
    drive(1, 0, 0, 1, '0);
    drive(1, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    // Full VC drops the second flit
    drive(1, 0, 1, 0, 64'h6840);
    drive(1, 0, 1, 0, 64'hABCDEF);
    drive(1, 1, 0, 0, '0);
    drive(1, 1, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    // Reset discards buffered flits
    drive(1, 0, 1, 1, 64'hDEF123);
    drive(1, 1, 1, 1, 64'h11A11);
    drive(0, 0, 0, 0, '0);
    drive(1, 1, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    drive(1, 1, 0, 0, '0);
    // Randomized traffic, with occasional polarity holds and resets
    p = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) p = ~p;
      drive(($urandom_range(0, 49) != 0), p, ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 3), {$urandom, $urandom});
    end
    @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_input_channel.md
Name: router_input_channel

Overview:
- Input port of a mesh NoC router with two virtual channels (VC0 = even, VC1 = odd) that alternate by cycle polarity.
- The link side writes the VC selected by `polarity`. The router-internal side reads the other VC (`~polarity`).
- It sits between an upstream link (send/ready handshake) and the router's switch/arbiter, which stalls it with `blocked`.

Parameters:
- DATA_W, 64, flit width in bits.
- DEPTH, 1, entries per VC FIFO. Power of two, 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- polarity  in  1  cycle parity from the router. 0: link writes VC0, switch reads VC1. 1: link writes VC1, switch reads VC0.
- send  in  1  upstream presents a valid flit on data_in this cycle.
- blocked  in  1  downstream cannot take the flit on data_out this cycle.
- data_in  in  DATA_W  incoming flit.
- ready  out  1  the VC selected by polarity can accept a flit this cycle.
- data_out  out  DATA_W  head flit of VC[~polarity].

Behaviour:
- Reset is synchronous, active-low (reset==0 at posedge clk):
  - VC counts, read pointers and write pointers clear to 0.
  - Stored data is don't-care.
  - While reset==0, ready=0 and data_out=0. When reset is released, ready=1 and data_out=0.
- ready is combinational: (reset==1) && count[polarity] < DEPTH.
- Write: at posedge, if send && ready, data_in is pushed into VC[polarity] (write pointer increments, wrap modulo DEPTH; count+1).
  - send && !ready: the flit is dropped, no state change.
  - send is ignored during reset.
- data_out is combinational: head entry of VC[~polarity] if count[~polarity] > 0, else all zeros.
- Read/pop: at posedge, if !blocked && count[~polarity] > 0, the head of VC[~polarity] is consumed (read pointer increments, wrap modulo DEPTH; count-1).
  - blocked=1: the head stays, data_out is unchanged and count is unchanged.
- Simultaneous push and pop always target different VCs, so both occur in the same cycle without conflict.
- Latency:
  - A flit written at edge N in polarity p becomes visible on data_out in the first following cycle whose polarity is ~p. With polarity toggling every cycle, that is the cycle right after edge N.
  - Minimum residency is one cycle.
- Ordering: per-VC FIFO order is preserved; there is no ordering guarantee between VCs.
- polarity may stay constant for several cycles: the same VC keeps receiving writes until it is full, while the other VC keeps draining.
- Reset mid-operation discards all buffered flits. No flit is output after reset until a new write.

Optional Feature:
- Macro ROUTER_INPUT_CHANNEL_ASSERT_EN.
- When defined, simulation-only checks are compiled in:
  - send while ready==0 (outside reset): error report naming the dropped flit value.
  - count overflow or underflow on either VC: fatal.
  - any X on polarity, send or blocked after reset release: error.
- When undefined, no checking logic exists; RTL behaviour is identical either way.

Decomposition:
- Shared package router_pkg:
  - DATA_W default;
  - VC index constants VC_EVEN=0 and VC_ODD=1;
  - flit typedef (logic [DATA_W-1:0]).
- One sub-module is natural: router_vc_fifo (DEPTH-entry FIFO with push, pop, head, count, full, empty), instantiated twice.
- The top level muxes push, pop and head by polarity.

Test Plan:
- Hold reset=0 for 2 cycles, then release → ready=0 and data_out=0 during reset; ready=1 and data_out=0 after release.
- polarity=0, send=1, data_in=0xFA50 at one edge; next cycle polarity=1, blocked=0 → data_out=0xFA50 in that cycle and VC0 is empty after the edge (data_out=0 when polarity returns to 0 on empty VC1).
- Toggle polarity each cycle and send 0xFA50, 0x6840, 0xFFFF, 0xC7D4 back-to-back with blocked=0 → data_out shows them in that order, each one cycle after its write, with no loss.
- Write 0x12345678 into VC1; assert blocked=1 for 2 read-opportunity cycles → data_out holds 0x12345678 and is not consumed; after blocked=0 it is popped once.
- DEPTH=1, polarity held 0: send 0x6840 then 0xABCDEF → ready=0 on the second cycle and 0xABCDEF is dropped. Switching polarity to 1 outputs 0x6840 only.
- Fill both VCs (0xDEF123 in VC0, 0x11A11 in VC1), assert reset=0 for 1 cycle → data_out=0 and ready=1 after release; nothing is output on the following cycles.
